// File: rtl/timer_pkg.sv
// timer_pkg: shared direction constants and per-stage modulus extraction for the timer chain
package timer_pkg;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    function automatic int mod_of(input logic [255:0] mod_vec, input int i, input int digit_w = 4);
        return int'((mod_vec >> (i * (digit_w + 1))) & ((256'd1 << (digit_w + 1)) - 256'd1));
    endfunction
endpackage

// File: rtl/modn_digit.sv
// modn_digit: one modulo-MOD up/down digit with clamped load, clear and registered wrap pulse
module modn_digit
    import timer_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int MOD     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               clear,
    output logic [DIGIT_W-1:0] cnt,
    output logic               term,
    output logic               wrap_pls
);
    localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);
    logic [DIGIT_W-1:0] r_cnt, w_nxt, w_step, w_clamp;
    logic               r_wrap;
    assign term     = (dir == DIR_DOWN) ? (r_cnt == '0) : (r_cnt == MAX);
    assign cnt      = r_cnt;
    assign wrap_pls = r_wrap;
    always_comb begin
        w_clamp = (load_val > MAX) ? MAX : load_val;
        w_step  = (dir == DIR_DOWN) ? (term ? MAX : r_cnt - DIGIT_W'(1))
                                    : (term ? '0  : r_cnt + DIGIT_W'(1));
        w_nxt   = clear ? '0 : load ? w_clamp : en ? w_step : r_cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            r_wrap <= ~clear & ~load & en & term;
        end
    end
endmodule

// File: rtl/modn_timer_chain.sv
// modn_timer_chain: single-clock cascade of modulo-N digits with look-ahead carry enables
module modn_timer_chain
    import timer_pkg::*;
#(
    parameter int                                  NUM_STAGES = 4,
    parameter int                                  DIGIT_W    = 4,
    parameter logic [NUM_STAGES*(DIGIT_W+1)-1:0]   MOD_VEC    = {5'd6, 5'd10, 5'd6, 5'd10}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_i,
    input  logic                          dir_i,
    input  logic                          load_i,
    input  logic [NUM_STAGES*DIGIT_W-1:0] load_val_i,
    input  logic                          clear_i,
    output logic [NUM_STAGES*DIGIT_W-1:0] cnt_o,
    output logic [NUM_STAGES-1:0]         carry_o,
    output logic                          wrap_o,
    output logic                          zero_o
);
    localparam logic [255:0] MV = 256'(MOD_VEC);
    logic [NUM_STAGES:0]   w_en;
    logic [NUM_STAGES-1:0] w_term;
    logic                  r_wrap;
    assign w_en[0] = tick_i;
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        assign w_en[g+1] = w_en[g] & w_term[g];
        modn_digit #(
            .DIGIT_W (DIGIT_W),
            .MOD     (mod_of(MV, g, DIGIT_W))
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (w_en[g]),
            .dir      (dir_i),
            .load     (load_i),
            .load_val (load_val_i[g*DIGIT_W +: DIGIT_W]),
            .clear    (clear_i),
            .cnt      (cnt_o[g*DIGIT_W +: DIGIT_W]),
            .term     (w_term[g]),
            .wrap_pls (carry_o[g])
        );
    end
    // whole-chain wrap is the enable that would ripple past the top digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wrap <= 1'b0;
        else        r_wrap <= ~clear_i & ~load_i & w_en[NUM_STAGES];
    end
    assign wrap_o = r_wrap;
    assign zero_o = ~|cnt_o;
endmodule

// File: tb/tb_modn_timer_chain.sv
// tb_modn_timer_chain: vector table, corner sequences and random run against a mixed-radix value model
module tb_modn_timer_chain;
    logic        clk = 1'b0, rst_n = 1'b0, tick_i = 1'b0, dir_i = 1'b0, load_i = 1'b0, clear_i = 1'b0;
    logic [15:0] load_val_i = '0, cnt_o;
    logic [3:0]  carry_o;
    logic        wrap_o, zero_o;
    int          n_chk = 0, n_pass = 0;
    int          mods[4] = '{10, 6, 10, 6};
    int          v = 0;
    logic [15:0] m_cnt;
    logic [3:0]  m_carry;
    logic        m_wrap;

    modn_timer_chain dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .dir_i(dir_i), .load_i(load_i),
        .load_val_i(load_val_i), .clear_i(clear_i), .cnt_o(cnt_o), .carry_o(carry_o),
        .wrap_o(wrap_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit t, d, l, c;
        logic [15:0] lv, cnt;
        logic [3:0]  carry;
        bit          wrap;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    function automatic logic [15:0] digits_of(input int val);
        logic [15:0] r = '0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((val / p) % mods[i]);
            p *= mods[i];
        end
        return r;
    endfunction

    // model state is the elapsed count as one integer in [0, 3600)
    task automatic step(input bit t, input bit d, input bit l, input logic [15:0] lv, input bit c);
        int p, dg;
        tick_i = t; dir_i = d; load_i = l; load_val_i = lv; clear_i = c;
        @(posedge clk);
        m_carry = '0;
        m_wrap  = 1'b0;
        if (c) v = 0;
        else if (l) begin
            v = 0; p = 1;
            for (int i = 0; i < 4; i++) begin
                dg = int'(lv[4*i +: 4]);
                if (dg >= mods[i]) dg = mods[i] - 1;
                v += dg * p;
                p *= mods[i];
            end
        end else if (t) begin
            p = 1;
            for (int i = 0; i < 4; i++) begin
                p *= mods[i];
                m_carry[i] = d ? (v % p == 0) : ((v + 1) % p == 0);
            end
            m_wrap = d ? (v == 0) : (v == 3599);
            v = d ? (v + 3599) % 3600 : (v + 1) % 3600;
        end
        m_cnt = digits_of(v);
        #1;
    endtask

    initial begin
        int wraps, c0, bad;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt_o, 0);
        chk("rst_zero", zero_o, 1);
        chk("rst_carry", carry_o, 0);
        chk("rst_wrap", wrap_o, 0);
        @(negedge clk) rst_n = 1'b1;

        vecs.push_back('{t:0, d:0, l:1, c:0, lv:16'h5959, cnt:16'h5959, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:0, c:0, lv:16'h0000, cnt:16'h0000, carry:4'hF, wrap:1});
        vecs.push_back('{t:0, d:0, l:0, c:0, lv:16'h0000, cnt:16'h0000, carry:4'h0, wrap:0});
        vecs.push_back('{t:0, d:0, l:1, c:0, lv:16'h1000, cnt:16'h1000, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:1, l:0, c:0, lv:16'h0000, cnt:16'h0959, carry:4'h7, wrap:0});
        vecs.push_back('{t:1, d:0, l:1, c:1, lv:16'h1234, cnt:16'h0000, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:1, c:0, lv:16'h1234, cnt:16'h1234, carry:4'h0, wrap:0});
        vecs.push_back('{t:0, d:0, l:1, c:0, lv:16'h9F9F, cnt:16'h5959, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:1, l:0, c:0, lv:16'h0000, cnt:16'h5958, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:0, c:0, lv:16'h0000, cnt:16'h5959, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:0, c:0, lv:16'h0000, cnt:16'h0000, carry:4'hF, wrap:1});
        vecs.push_back('{t:1, d:0, l:0, c:0, lv:16'h0000, cnt:16'h0001, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:1, l:0, c:0, lv:16'h0000, cnt:16'h0000, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:1, l:0, c:0, lv:16'h0000, cnt:16'h5959, carry:4'hF, wrap:1});
        vecs.push_back('{t:1, d:1, l:0, c:0, lv:16'h0000, cnt:16'h5958, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:0, c:0, lv:16'h0000, cnt:16'h5959, carry:4'h0, wrap:0});
        vecs.push_back('{t:1, d:0, l:0, c:1, lv:16'h0000, cnt:16'h0000, carry:4'h0, wrap:0});
        foreach (vecs[k]) begin
            step(vecs[k].t, vecs[k].d, vecs[k].l, vecs[k].lv, vecs[k].c);
            chk($sformatf("vec%0d_cnt", k), cnt_o, vecs[k].cnt);
            chk($sformatf("vec%0d_carry", k), carry_o, vecs[k].carry);
            chk($sformatf("vec%0d_wrap", k), wrap_o, vecs[k].wrap);
            chk($sformatf("vec%0d_zero", k), zero_o, vecs[k].cnt == 16'h0);
        end

        step(0, 0, 1, 16'h0358, 0);
        step(1, 0, 0, 16'h0000, 0);
        chk("pre_rst_cnt", cnt_o, 16'h0359);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt_o, 0);
        chk("async_rst_zero", zero_o, 1);
        chk("async_rst_carry", carry_o, 0);
        tick_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rst_cnt", cnt_o, 0);
        chk("hold_rst_wrap", wrap_o, 0);
        @(negedge clk) rst_n = 1'b1;
        v = 0;

        wraps = 0; c0 = 0; bad = 0;
        for (int k = 0; k < 3600; k++) begin
            step(1, 0, 0, 16'h0000, 0);
            wraps += int'(wrap_o);
            c0    += int'(carry_o[0]);
            if (cnt_o !== m_cnt || carry_o !== m_carry || wrap_o !== m_wrap) bad++;
        end
        chk("free_wraps", wraps, 1);
        chk("free_carry0", c0, 360);
        chk("free_final", cnt_o, 0);
        chk("free_track", bad, 0);

        for (int k = 0; k < 500; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 39) == 0);
            chk("rnd_cnt", cnt_o, m_cnt);
            chk("rnd_carry", carry_o, m_carry);
            chk("rnd_wrap", wrap_o, m_wrap);
            chk("rnd_zero", zero_o, m_cnt == 16'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
